sddr_init_refresh_seq: RTL and testbench

//  Command sequencer that drives the DDR3 PHY command inputs (ctl_cke/cs_n/ras_n/cas_n/we_n/addr/ba/odt)
//  and the DDR3 reset. It runs the JEDEC power-up/MRS/ZQCL sequence, then arbitrates the command bus

---
 rtl/sddr_init_refresh_seq_if.sv | 34 +++
 rtl/sddr_init_refresh_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_sddr_init_refresh_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sddr_init_refresh_seq_if.sv
// User command channel between the access controller and the DDR3 init/refresh sequencer.
//   usr_cmd_valid_i  controller -> sequencer  command valid
//   usr_cmd_ready_o  sequencer  -> controller command accepted when valid & ready
//   usr_cmd_i        controller -> sequencer  {ras_n, cas_n, we_n}
//   usr_addr_i       controller -> sequencer  command address
//   usr_ba_i         controller -> sequencer  command bank
interface sddr_init_refresh_seq_if #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned BANK_BITS = 3
) ();
    logic                 usr_cmd_valid_i;
    logic                 usr_cmd_ready_o;
    logic [2:0]           usr_cmd_i;
    logic [ADDR_BITS-1:0] usr_addr_i;
    logic [BANK_BITS-1:0] usr_ba_i;

    // Access controller side
    modport master (
        output usr_cmd_valid_i,
        output usr_cmd_i,
        output usr_addr_i,
        output usr_ba_i,
        input  usr_cmd_ready_o
    );

    // Sequencer side
    modport slave (
        input  usr_cmd_valid_i,
        input  usr_cmd_i,
        input  usr_addr_i,
        input  usr_ba_i,
        output usr_cmd_ready_o
    );
endinterface

// File: rtl/sddr_init_refresh_seq.sv
// DDR3 command sequencer: runs the power-up / MRS / ZQCL init sequence, then arbitrates the
// PHY command bus between periodic PREA+REF refresh and the user command stream.
// Ports:
//   in_ddr_clock_i   controller clock
//   in_reset_n_i     async active-low reset
//   usr              user command channel (slave modport; ready is combinational)
//   init_done_o      init complete, sticky until reset
//   ddr_reset_n_o    DDR3 device reset to PHY
//   ctl_cke_o, ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o, ctl_odt_o,
//   ctl_addr_o, ctl_ba_o   registered PHY command outputs
module sddr_init_refresh_seq #(
    parameter int unsigned BANK_BITS    = 3,
    parameter int unsigned ROW_BITS     = 13,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned T_RESET_CYC  = 40000,
    parameter int unsigned T_CKE_CYC    = 100000,
    parameter int unsigned T_XPR_CYC    = 72,
    parameter int unsigned T_MRD_CYC    = 4,
    parameter int unsigned T_MOD_CYC    = 12,
    parameter int unsigned T_ZQINIT_CYC = 512,
    parameter int unsigned T_RP_CYC     = 6,
    parameter int unsigned T_RFC_CYC    = 64,
    parameter int unsigned T_REFI_CYC   = 1560,
    parameter int unsigned T_GUARD_CYC  = 16,
    parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR0 = '0,
    parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR1 = '0,
    parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR2 = '0,
    parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR3 = '0
) (
    input  logic                 in_ddr_clock_i,
    input  logic                 in_reset_n_i,
    sddr_init_refresh_seq_if.slave usr,
    output logic                 init_done_o,
    output logic                 ddr_reset_n_o,
    output logic                 ctl_cke_o,
    output logic                 ctl_cs_n_o,
    output logic                 ctl_ras_n_o,
    output logic                 ctl_cas_n_o,
    output logic                 ctl_we_n_o,
    output logic                 ctl_odt_o,
    output logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] ctl_addr_o,
    output logic [BANK_BITS-1:0] ctl_ba_o
);

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned ADDR_BITS = ROW_BITS + $clog2(DATA_BITS / 8);

    // One shared sequencing counter, sized for the longest init/refresh wait
    localparam int unsigned T_MAX = umax(umax(umax(T_RESET_CYC, T_CKE_CYC), umax(T_XPR_CYC, T_MRD_CYC)),
                                         umax(umax(T_MOD_CYC, T_ZQINIT_CYC), umax(T_RP_CYC, T_RFC_CYC)));
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned REFI_W  = (T_REFI_CYC > 1) ? $clog2(T_REFI_CYC) : 1;
    localparam int unsigned GUARD_W = (T_GUARD_CYC > 1) ? $clog2(T_GUARD_CYC) : 1;

    localparam logic [GUARD_W-1:0]   GUARD_MAX = GUARD_W'(T_GUARD_CYC - 1);
    localparam logic [REFI_W-1:0]    REFI_LAST = REFI_W'(T_REFI_CYC - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_A10  = ADDR_BITS'(1024);

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_MRS  = 3'b000;
    localparam logic [2:0] CMD_REF  = 3'b001;
    localparam logic [2:0] CMD_PREA = 3'b010;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOP  = 3'b111;

    // ST_MRSn means "MRn was just issued, waiting before the next command"
    typedef enum logic [3:0] {
        ST_RST_HOLD,
        ST_CKE_WAIT,
        ST_XPR,
        ST_MRS2,
        ST_MRS3,
        ST_MRS1,
        ST_MRS0,
        ST_ZQ_WAIT,
        ST_IDLE,
        ST_WAIT_RP,
        ST_WAIT_RFC
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [REFI_W-1:0]    refi_cnt;
    logic [GUARD_W-1:0]   guard_cnt;
    logic                 pending;
    logic                 usr_accept;
    logic                 guard_ok;

    function automatic logic cnt_done(input logic [CNT_W-1:0] c, input int unsigned t);
        return c == CNT_W'(t - 1);
    endfunction

    // Refresh pre-empts new user commands as soon as it is pending
    assign usr.usr_cmd_ready_o = (state == ST_IDLE) && !pending;
    assign usr_accept          = usr.usr_cmd_valid_i && usr.usr_cmd_ready_o;
    assign guard_ok            = (guard_cnt == GUARD_MAX);

    // Sequencer FSM, timers and registered PHY command outputs
    always_ff @(posedge in_ddr_clock_i or negedge in_reset_n_i) begin
        if (!in_reset_n_i) begin
            state         <= ST_RST_HOLD;
            cnt           <= '0;
            refi_cnt      <= '0;
            guard_cnt     <= '0;
            pending       <= 1'b0;
            init_done_o   <= 1'b0;
            ddr_reset_n_o <= 1'b0;
            ctl_cke_o     <= 1'b0;
            ctl_cs_n_o    <= 1'b1;
            ctl_ras_n_o   <= 1'b1;
            ctl_cas_n_o   <= 1'b1;
            ctl_we_n_o    <= 1'b1;
            ctl_odt_o     <= 1'b0;
            ctl_addr_o    <= '0;
            ctl_ba_o      <= '0;
        end else begin
            // Default NOP; chip select stays deasserted until CKE is high
            ctl_cs_n_o <= !ctl_cke_o;
            {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_NOP;
            ctl_addr_o <= '0;
            ctl_ba_o   <= '0;
            ctl_odt_o  <= 1'b0;
            cnt        <= cnt + CNT_W'(1);

            // Cycles since the last accepted user command, saturating
            if (usr_accept) begin
                guard_cnt <= '0;
            end else if (!guard_ok) begin
                guard_cnt <= guard_cnt + GUARD_W'(1);
            end

            unique case (state)
                ST_RST_HOLD: begin
                    if (cnt_done(cnt, T_RESET_CYC)) begin
                        state         <= ST_CKE_WAIT;
                        cnt           <= '0;
                        ddr_reset_n_o <= 1'b1;
                    end
                end
                ST_CKE_WAIT: begin
                    if (cnt_done(cnt, T_CKE_CYC)) begin
                        state      <= ST_XPR;
                        cnt        <= '0;
                        ctl_cke_o  <= 1'b1;
                        ctl_cs_n_o <= 1'b0;
                    end
                end
                ST_XPR: begin
                    if (cnt_done(cnt, T_XPR_CYC)) begin
                        state      <= ST_MRS2;
                        cnt        <= '0;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_MRS;
                        ctl_ba_o   <= BANK_BITS'(2);
                        ctl_addr_o <= MR2;
                    end
                end
                ST_MRS2: begin
                    if (cnt_done(cnt, T_MRD_CYC)) begin
                        state      <= ST_MRS3;
                        cnt        <= '0;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_MRS;
                        ctl_ba_o   <= BANK_BITS'(3);
                        ctl_addr_o <= MR3;
                    end
                end
                ST_MRS3: begin
                    if (cnt_done(cnt, T_MRD_CYC)) begin
                        state      <= ST_MRS1;
                        cnt        <= '0;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_MRS;
                        ctl_ba_o   <= BANK_BITS'(1);
                        ctl_addr_o <= MR1;
                    end
                end
                ST_MRS1: begin
                    if (cnt_done(cnt, T_MRD_CYC)) begin
                        state      <= ST_MRS0;
                        cnt        <= '0;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_MRS;
                        ctl_ba_o   <= BANK_BITS'(0);
                        ctl_addr_o <= MR0;
                    end
                end
                ST_MRS0: begin
                    if (cnt_done(cnt, T_MOD_CYC)) begin
                        state      <= ST_ZQ_WAIT;
                        cnt        <= '0;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_ZQCL;
                        ctl_addr_o <= ADDR_A10;
                    end
                end
                ST_ZQ_WAIT: begin
                    if (cnt_done(cnt, T_ZQINIT_CYC)) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        init_done_o <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    cnt <= '0;
                    if (pending && guard_ok) begin
                        state      <= ST_WAIT_RP;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_PREA;
                        ctl_addr_o <= ADDR_A10;
                    end else if (usr_accept) begin
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= usr.usr_cmd_i;
                        ctl_addr_o <= usr.usr_addr_i;
                        ctl_ba_o   <= usr.usr_ba_i;
                    end
                end
                ST_WAIT_RP: begin
                    if (cnt_done(cnt, T_RP_CYC)) begin
                        state      <= ST_WAIT_RFC;
                        cnt        <= '0;
                        pending    <= 1'b0;
                        ctl_cs_n_o <= 1'b0;
                        {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} <= CMD_REF;
                    end
                end
                ST_WAIT_RFC: begin
                    if (cnt_done(cnt, T_RFC_CYC)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_RST_HOLD;
                    cnt   <= '0;
                end
            endcase

            // Refresh interval timer: held at 0 until init completes, then free-runs.
            // Placed after the FSM so a wrap wins over the clear on REF issue.
            if (!init_done_o) begin
                refi_cnt <= '0;
            end else if (refi_cnt == REFI_LAST) begin
                refi_cnt <= '0;
                pending  <= 1'b1;
            end else begin
                refi_cnt <= refi_cnt + REFI_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sddr_init_refresh_seq.sv
// Directed bench for sddr_init_refresh_seq with shortened timing parameters.
module tb_sddr_init_refresh_seq;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        ddr_reset_n;
    logic        cke, cs_n, ras_n, cas_n, we_n, odt;
    logic [13:0] addr;
    logic [2:0]  ba;

    int cyc;
    int n_checks;
    int n_errors;
    logic [63:0] log_q[$];

    sddr_init_refresh_seq_if #(.ADDR_BITS(14), .BANK_BITS(3)) u_if ();

    sddr_init_refresh_seq #(
        .BANK_BITS(3), .ROW_BITS(13), .DATA_BITS(16),
        .T_RESET_CYC(10), .T_CKE_CYC(20), .T_XPR_CYC(5), .T_MRD_CYC(4),
        .T_MOD_CYC(12), .T_ZQINIT_CYC(16), .T_RP_CYC(3), .T_RFC_CYC(8),
        .T_REFI_CYC(100), .T_GUARD_CYC(4),
        .MR0(14'h0123), .MR1(14'h0044), .MR2(14'h0208), .MR3(14'h0004)
    ) u_dut (
        .in_ddr_clock_i (clk),
        .in_reset_n_i   (rst_n),
        .usr            (u_if),
        .init_done_o    (init_done),
        .ddr_reset_n_o  (ddr_reset_n),
        .ctl_cke_o      (cke),
        .ctl_cs_n_o     (cs_n),
        .ctl_ras_n_o    (ras_n),
        .ctl_cas_n_o    (cas_n),
        .ctl_we_n_o     (we_n),
        .ctl_odt_o      (odt),
        .ctl_addr_o     (addr),
        .ctl_ba_o       (ba)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [63:0] mk(input int c, input logic [2:0] cmd,
                                       input logic [2:0] b, input logic [13:0] a);
        return {28'd0, 16'(c), cmd, b, a};
    endfunction

    // Record every non-NOP command
    always @(negedge clk) begin
        if (rst_n && !cs_n && ({ras_n, cas_n, we_n} != 3'b111))
            log_q.push_back(mk(cyc, {ras_n, cas_n, we_n}, ba, addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) check("wait_cyc", 64'(cyc), 64'(target));
    endtask

    task automatic expect_cmd(input string tag, input int c, input logic [2:0] cmd,
                              input logic [2:0] b, input logic [13:0] a);
        logic [63:0] got;
        got = '0;
        if (log_q.size() != 0) got = log_q.pop_front();
        check(tag, got, mk(c, cmd, b, a));
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_ctl"}, {ddr_reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, init_done,
                              u_if.usr_cmd_ready_o}, 64'b0_0_1_111_0_0_0);
        check({tag, "_addr_ba"}, {addr, ba}, 64'd0);
    endtask

    task automatic expect_init_cmds(input string tag);
        expect_cmd({tag, "_mr2"},  35, 3'b000, 3'd2, 14'h0208);
        expect_cmd({tag, "_mr3"},  39, 3'b000, 3'd3, 14'h0004);
        expect_cmd({tag, "_mr1"},  43, 3'b000, 3'd1, 14'h0044);
        expect_cmd({tag, "_mr0"},  47, 3'b000, 3'd0, 14'h0123);
        expect_cmd({tag, "_zqcl"}, 59, 3'b110, 3'd0, 14'h0400);
    endtask

    // Release reset with a user command held valid, to confirm it is ignored during init
    task automatic release_rst();
        log_q.delete();
        u_if.usr_cmd_valid_i = 1'b1;
        u_if.usr_cmd_i       = 3'b100;
        u_if.usr_addr_i      = 14'h3fff;
        u_if.usr_ba_i        = 3'd7;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_init(input string tag);
        wait_cyc(9);
        check({tag, "_rstn9"}, ddr_reset_n, 1'b0);
        wait_cyc(10);
        check({tag, "_rstn10"}, {ddr_reset_n, cke, u_if.usr_cmd_ready_o}, 3'b100);
        wait_cyc(29);
        check({tag, "_cke29"}, {cke, cs_n}, 2'b01);
        wait_cyc(30);
        check({tag, "_cke30"}, {cke, cs_n, ras_n, cas_n, we_n}, 5'b10111);
        wait_cyc(74);
        check({tag, "_done74"}, {init_done, u_if.usr_cmd_ready_o}, 2'b00);
        wait_cyc(75);
        check({tag, "_done75"}, {init_done, u_if.usr_cmd_ready_o, odt}, 3'b110);
        u_if.usr_cmd_valid_i = 1'b0;
        expect_init_cmds(tag);
        check({tag, "_extra"}, 64'(log_q.size()), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        u_if.usr_cmd_valid_i = 1'b0;
        u_if.usr_cmd_i       = 3'b111;
        u_if.usr_addr_i      = '0;
        u_if.usr_ba_i        = '0;
        repeat (3) @(negedge clk);
        check_rst("t0_reset");

        // Power-up sequence with user valid asserted throughout init
        release_rst();
        check_init("t1");

        // Idle refresh: timer cleared at 75, wraps at 175
        wait_cyc(174);
        check("t2_rdy174", u_if.usr_cmd_ready_o, 1'b1);
        wait_cyc(175);
        check("t2_rdy175", u_if.usr_cmd_ready_o, 1'b0);
        wait_cyc(186);
        check("t2_rdy186", u_if.usr_cmd_ready_o, 1'b0);
        wait_cyc(187);
        check("t2_rdy187", u_if.usr_cmd_ready_o, 1'b1);
        expect_cmd("t2_prea", 176, 3'b010, 3'd0, 14'h0400);
        expect_cmd("t2_ref",  179, 3'b001, 3'd0, 14'h0000);
        check("t2_extra", 64'(log_q.size()), 64'd0);

        // Back-to-back user stream across the wrap at 275
        for (int c = 260; c <= 288; c++) begin
            wait_cyc(c);
            if (c == 274) check("t3_rdy274", u_if.usr_cmd_ready_o, 1'b1);
            if (c == 275) check("t3_rdy275", u_if.usr_cmd_ready_o, 1'b0);
            u_if.usr_cmd_valid_i = 1'b1;
            u_if.usr_cmd_i       = c[0] ? 3'b101 : 3'b100;
            u_if.usr_addr_i      = 14'(c);
            u_if.usr_ba_i        = 3'(c);
        end
        wait_cyc(289);
        u_if.usr_cmd_valid_i = 1'b0;
        wait_cyc(290);
        check("t3_rdy290", u_if.usr_cmd_ready_o, 1'b1);
        wait_cyc(295);
        for (int c = 260; c <= 274; c++)
            expect_cmd("t3_usr", c + 1, c[0] ? 3'b101 : 3'b100, 3'(c), 14'(c));
        expect_cmd("t3_prea", 279, 3'b010, 3'd0, 14'h0400);
        expect_cmd("t3_ref",  282, 3'b001, 3'd0, 14'h0000);
        check("t3_extra", 64'(log_q.size()), 64'd0);

        // Single command accepted on the wrap edge 375, then held valid while refresh runs
        wait_cyc(374);
        u_if.usr_cmd_valid_i = 1'b1;
        u_if.usr_cmd_i       = 3'b101;
        u_if.usr_addr_i      = 14'h0155;
        u_if.usr_ba_i        = 3'd5;
        wait_cyc(375);
        check("t4_rdy375", u_if.usr_cmd_ready_o, 1'b0);
        wait_cyc(389);
        u_if.usr_cmd_valid_i = 1'b0;
        wait_cyc(395);
        expect_cmd("t4_usr",  375, 3'b101, 3'd5, 14'h0155);
        expect_cmd("t4_prea", 379, 3'b010, 3'd0, 14'h0400);
        expect_cmd("t4_ref",  382, 3'b001, 3'd0, 14'h0000);
        check("t4_extra", 64'(log_q.size()), 64'd0);

        // Reset during WAIT_RFC (REF at 479)
        wait_cyc(481);
        expect_cmd("t5_prea", 476, 3'b010, 3'd0, 14'h0400);
        expect_cmd("t5_ref",  479, 3'b001, 3'd0, 14'h0000);
        rst_n = 1'b0;
        #1;
        check_rst("t5_rfc_reset");

        // Restarted init, then reset during ZQ_WAIT
        release_rst();
        wait_cyc(65);
        check("t5_zq_state", {cke, init_done}, 2'b10);
        expect_init_cmds("t5_rerun");
        rst_n = 1'b0;
        #1;
        check_rst("t5_zq_reset");

        // Full sequence again after release
        release_rst();
        check_init("t5_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
